fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core. It replaces the fixed two-source, two-stage forwarding logic. The block tracks destination tags of in-flight instructions through a configurable number of post-ID stages and computes per-source forward selects for the EX stage. It also raises a load-use stall for the ID stage and counts stall cycles. It sits beside the ID/EX pipeline registers and is driven by the decoder and the branch/flush logic.

## Interface
- NUM_SRC, 2: source operands per instruction.
- STAGES, 3: tracked stages after ID, indexed 0=EX, 1=MEM, 2=WB, ...; minimum 2.
- REG_AW, 5: register index width.
- LOAD_STAGE, 2: first stage index whose output carries load data; range 1..STAGES-1.
- CNT_W, 16: stall counter width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- id_valid_i  in  1  an instruction is present in ID.
- id_rs_i  in  NUM_SRC*REG_AW  ID source indices; source k occupies bits [k*REG_AW +: REG_AW].
- id_rd_i  in  REG_AW  ID destination index.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  kill the ID instruction this cycle, so a bubble enters EX.
- stall_o  out  1  load-use stall: hold PC and IF/ID, insert a bubble into EX.
- fwd_sel_o  out  NUM_SRC*FW  per-source forward select for the EX instruction, where FW = clog2(STAGES).
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o=1.

## Operation
- Each stage s holds: valid, rd, regwrite, memread. Stage 0 also holds the NUM_SRC source indices.
- A stage is a producer iff valid && regwrite && rd != 0.
- Every cycle, stage s takes the contents of stage s-1 for s ≥ 1. Stage 0 captures ID when id_valid_i && !stall_o && !flush_i; otherwise stage 0 becomes a bubble with valid=0.
- Priority on every cycle: rst_i over flush_i over stall_o. flush_i suppresses stall_o for that cycle, and stall_o does not assert while flush_i=1.
- Forward select for source k uses the stage-0 source index and considers stages 1..STAGES-1 only.
  - fwd_sel = s for the lowest-index producer stage s whose rd equals the source; the youngest producer wins.
  - fwd_sel = 0 means read from the register file.
  - An rs of 0 always gives 0. A bubble in stage 0 gives 0 for all sources.
- Encoding with defaults: 0 = RF, 1 = MEM, 2 = WB. The datapath mux must follow this encoding.
- Load-use stall condition: id_valid_i && !flush_i && some source k of ID matches a producer at stage p with memread=1 and p ≤ LOAD_STAGE-2.
  - With default parameters this reduces to: a load in EX whose rd equals an ID source, giving exactly one stall cycle.
  - With LOAD_STAGE=3 the stall lasts two cycles.
- A load producing x0 never stalls.
- Stall counter: increments by 1 on each cycle with stall_o=1 and saturates at all-ones. It does not wrap.
- Same-cycle WB write and ID read of the same register is resolved by the register file's write-first behaviour, not by this block.

## Timing
- Reset: all stage valid bits clear and stall_cnt_o=0. In the first cycle after reset, stall_o=0 and fwd_sel_o=0, because all outputs are derived from cleared state.
- stall_o is combinational from ID inputs and stage state, with zero latency.
- fwd_sel_o is combinational from registered stage state only. It is valid for the instruction in EX during the same cycle.
- Pipeline timing: an instruction accepted at edge n is in EX during cycle n+1 and in stage s during cycle n+1+s.
- Reset asserted mid-operation clears all in-flight tags at the next edge; no forwarding happens from pre-reset instructions.

## Structure
- The shared package fwd_pkg holds:
  - the FW width function (clog2);
  - the constants FWD_RF=0 and FWD_FROM_MEM=1;
  - the stage-record field widths.
- Sub-module fwd_match is combinational and instantiated NUM_SRC times. It takes one source index plus the vectors of producer stage rd/valid, and returns a priority-encoded select.
- The top level holds the stage shift register, the stall logic and the counter.

## Test plan
- Back-to-back ALU producer: add x5 issued, then sub using rs1=x5 on the next cycle. Required: fwd_sel[0]=1 while sub is in EX; with one unrelated instruction between them, fwd_sel[0]=2.
- Double producer: add x5 issued, add x5 issued, then a reader of x5. Required: fwd_sel=1 (the youngest); the WB copy is ignored.
- Load-use: lw x7 issued, then an instruction with rs2=x7. Required: stall_o=1 for exactly one cycle, a bubble in EX, then fwd_sel[1]=2 and stall_cnt_o=1. With LOAD_STAGE=3, STAGES=4: a 2-cycle stall.
- x0 and flush:
  - lw x0 followed by a reader of x0: stall_o=0 and fwd_sel=0.
  - flush_i=1 while a load-use condition is present: stall_o=0 and stage 0 becomes a bubble.
- Reset mid-stream: rst_i asserted with three valid producers in flight. Required: the next cycle shows fwd_sel=0, stall_o=0 and stall_cnt_o=0.
- Counter saturation with CNT_W=4: force 20 stall cycles. Required: stall_cnt_o holds at 15.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Select encoding, stage-record fields and the select width.
package fwd_pkg;

  localparam int FWD_RF       = 0;
  localparam int FWD_FROM_MEM = 1;

  localparam int VLD_W = 1;
  localparam int RW_W  = 1;
  localparam int MR_W  = 1;

  typedef struct packed {
    logic vld;
    logic rw;
    logic mr;
  } stg_ctl_t;

  function automatic int fw_width(input int stages);
    return (stages < 2) ? 1 : $clog2(stages);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source priority match against producer stages 1..STAGES-1.
// The youngest (lowest-index) producer wins.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_AW = 5,
  parameter int FW     = 2
) (
  input  logic                           en_i,
  input  logic [REG_AW-1:0]              rs_i,
  input  logic [(STAGES-1)*REG_AW-1:0]   prod_rd_i,
  input  logic [STAGES-2:0]              prod_vld_i,
  output logic [FW-1:0]                  sel_o
);

  // Entry j describes stage j+1; scan oldest first so the youngest sticks.
  always_comb begin
    sel_o = FW'(FWD_RF);
    if (en_i && rs_i != '0) begin
      for (int j = STAGES - 2; j >= 0; j--) begin
        if (prod_vld_i[j] &&
            prod_rd_i[j*REG_AW +: REG_AW] == rs_i) begin
          sel_o = FW'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight
// destination tags, drives EX forward selects and the ID stall.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int STAGES     = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]            id_rs_i,
  input  logic [REG_AW-1:0]                    id_rd_i,
  input  logic                                 id_regwrite_i,
  input  logic                                 id_memread_i,
  input  logic                                 flush_i,
  output logic                                 stall_o,
  output logic [NUM_SRC*fw_width(STAGES)-1:0]  fwd_sel_o,
  output logic [CNT_W-1:0]                     stall_cnt_o
);

  localparam int FW = fw_width(STAGES);

  stg_ctl_t [STAGES-1:0]              ctl_q, ctl_d;
  logic [STAGES-1:0][REG_AW-1:0]      rd_q, rd_d;
  logic [NUM_SRC-1:0][REG_AW-1:0]     rs_q, rs_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;

  logic [STAGES-1:0] prod;
  logic              hazard;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      prod[s] = ctl_q[s].vld && ctl_q[s].rw && rd_q[s] != '0;
    end
  end

  // Loads still too young to forward from force the ID reader to wait.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (s + 2 <= LOAD_STAGE && prod[s] && ctl_q[s].mr &&
            rd_q[s] == id_rs_i[k*REG_AW +: REG_AW]) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall_o = !rst_i && id_valid_i && !flush_i && hazard;

  always_comb begin
    ctl_d[0].vld = id_valid_i && !stall_o && !flush_i;
    ctl_d[0].rw  = id_regwrite_i;
    ctl_d[0].mr  = id_memread_i;
    rd_d[0]      = id_rd_i;
    rs_d         = id_rs_i;
    for (int s = 1; s < STAGES; s++) begin
      ctl_d[s] = ctl_q[s-1];
      rd_d[s]  = rd_q[s-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_q <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      cnt_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      rd_q  <= rd_d;
      rs_q  <= rs_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match #(
      .STAGES (STAGES),
      .REG_AW (REG_AW),
      .FW     (FW)
    ) u_match (
      .en_i       (ctl_q[0].vld),
      .rs_i       (rs_q[k]),
      .prod_rd_i  (rd_q[STAGES-1:1]),
      .prod_vld_i (prod[STAGES-1:1]),
      .sel_o      (fwd_sel_o[k*FW +: FW])
    );
  end

endmodule
